// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - default sizing parameters
//   - FSM state encoding (IDLE=0, CLEAR=1)
//   - helper that returns the LSB of a slot in a flattened per-port bus
package regfile_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefNumRead   = 2;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } state_e;

  // Port p of a flattened bus occupies [slice_lsb(p, w) +: w].
  function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   clr_all           zero every busy bit at the next edge (overrides set/clear)
//   set_en, set_addr  mark set_addr busy at the next edge (address 0 never set)
//   clr_en, clr_addr  clear busy at clr_addr at the next edge; set wins on a tie
//   qaddr             flattened query addresses, NUM_READ slots
//   qbusy             raw busy bit per query slot
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_READ   = DefNumRead
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_all,
  input  logic                           set_en,
  input  logic [ADDR_WIDTH-1:0]          set_addr,
  input  logic                           clr_en,
  input  logic [ADDR_WIDTH-1:0]          clr_addr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] qaddr,
  output logic [NUM_READ-1:0]            qbusy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [Depth-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
    if (clr_all) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    qbusy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      qbusy[i] = busy_q[qaddr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, load-hazard scoreboard and
// a sequential clear engine (entered on flush or reset).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 start a clear sequence from IDLE
//   we_a, wa_a, wd_a      ALU writeback
//   we_b, wa_b, wd_b      load writeback; also clears the busy bit of wa_b
//   iss_valid, iss_rd     issue of a load targeting iss_rd (sets its busy bit)
//   ra                    flattened read addresses, NUM_READ slots
//   rdata                 flattened read data (combinational, bypassed)
//   rbusy                 per-port hazard flag
//   ready                 high only in IDLE
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_READ   = DefNumRead
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           we_a,
  input  logic [ADDR_WIDTH-1:0]          wa_a,
  input  logic [DATA_WIDTH-1:0]          wd_a,
  input  logic                           we_b,
  input  logic [ADDR_WIDTH-1:0]          wa_b,
  input  logic [DATA_WIDTH-1:0]          wd_b,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_rd,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  output logic                           ready
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  clear_we;
  logic                  idle;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [NUM_READ-1:0]   busy_raw;

  // FSM next state
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clear_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        clear_we = 1'b1;
        idx_d    = idx_q + ADDR_WIDTH'(1);
        if (idx_q == {ADDR_WIDTH{1'b1}}) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage: port B is written last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we) begin
        mem_q[idx_q] <= '0;
      end else if (state_q == StIdle) begin
        if (we_a && wa_a != '0) mem_q[wa_a] <= wd_a;
        if (we_b && wa_b != '0) mem_q[wa_b] <= wd_b;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_all  ((state_q == StIdle && flush) || state_q == StClear),
    .set_en   (iss_valid && state_q == StIdle),
    .set_addr (iss_rd),
    .clr_en   (we_b && state_q == StIdle),
    .clr_addr (wa_b),
    .qaddr    (ra),
    .qbusy    (busy_raw)
  );

  assign idle  = (state_q == StIdle) && !rst;
  assign ready = idle;

  // Read ports: zero register, then B bypass, then A bypass, then storage.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      a = ra[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
      if (idle && a != '0) begin
        if (we_b && wa_b == a)      rdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = wd_b;
        else if (we_a && wa_a == a) rdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = wd_a;
        else                        rdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = mem_q[a];
        // A load writing back this cycle resolves the hazard.
        rbusy[i] = busy_raw[i] && !(we_b && wa_b == a);
      end
    end
  end

endmodule
